fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the LEGv8 core. Owns the program counter, drives the byte address of
//  the combinational InstructionMemory and captures the returned 32-bit word into an IF/ID register.
//  That register feeds decode (ControlUnit/RegisterBank) through a valid/ready handshake.
//  Supports branch redirect, decode back-pressure, a halt instruction and an address-fault stop.
// PARAMETERS
//  RESET_PC    64'h0            PC loaded on reset
//  IMEM_BYTES  64               instruction memory size in bytes (16 words)
//  HALT_INSTR  32'hD440_0000    encoding that stops fetch (HLT #0)
// PORTS
//  clk          in   1   core clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  imem_adr     out  64  byte address to InstructionMemory (= pc, combinational)
//  imem_instr   in   32  word returned by InstructionMemory, same cycle
//  if_valid     out  1   IF/ID register holds an instruction
//  if_pc        out  64  PC of the held instruction
//  if_instr     out  32  held instruction word
//  id_ready     in   1   decode accepts the IF/ID contents this cycle
//  redirect     in   1   taken branch / flush request from downstream
//  redirect_pc  in   64  new fetch target when redirect=1
//  halted       out  1   HALT_INSTR issued, fetch stopped
//  fault        out  1   fetch address misaligned or >= IMEM_BYTES, sticky
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   pc=RESET_PC, state=RUN, if_valid=0, if_pc=0, if_instr=0, halted=0, fault=0.
//  States: RUN, HALTED, FAULT. halted=(state==HALTED), fault=(state==FAULT), both registered.
//  fire = (state==RUN) && !redirect && (!if_valid || id_ready).
//  On fire:
//   - if_valid<=1, if_pc<=pc, if_instr<=imem_instr.
//   - Latency: a word fetched at PC p appears on if_* the cycle after p is on imem_adr.
//   - If imem_instr==HALT_INSTR: the HLT is still issued, pc holds, state<=HALTED.
//   - Else if pc+4 >= IMEM_BYTES: pc holds, state<=FAULT (the last word is issued).
//   - Else pc<=pc+4. Arithmetic is 64-bit unsigned; no wrap-around.
//  Handshake:
//   - If if_valid && !id_ready, if_pc/if_instr/pc are frozen (stall); the output never changes while held.
//   - If if_valid && id_ready && !fire, if_valid<=0.
//   - First fire occurs in the first cycle after rst_n deasserts.
//  Redirect (priority over stall, halt and fire; ignored only in FAULT):
//   - if_valid<=0 (the held instruction is flushed even if id_ready=0), pc<=redirect_pc.
//   - If redirect_pc[1:0]!=0 or redirect_pc>=IMEM_BYTES: state<=FAULT.
//   - Otherwise state<=RUN; this resumes fetch from HALTED.
//   - The first redirected word appears on if_* 2 cycles after redirect is sampled.
//  FAULT: no fire, if_valid drains via id_ready, pc frozen. Only rst_n leaves FAULT.
//  HALTED: the held HLT still drains normally; the stage leaves HALTED only by redirect or reset.
//  Reset mid-stall or mid-redirect: all state returns to the reset values immediately (async).
// STRUCTURE
//  Package fetch_pkg:
//   - typedef enum logic [1:0] {RUN, HALTED, FAULT} fetch_state_t
//   - INSTR_BYTES = 4
//   - HLT_ENC = 32'hD440_0000
//   - typedef struct {pc, instr} ifid_t
//  Sub-module if_id_reg: the handshake register.
//   - Ports: load, clear, hold, ifid_t in/out, valid.
//  fetch_stage keeps pc, the FSM and the next-pc/fault logic.
// TESTING (bench instantiates fetch_stage + InstructionMemory, MEM_SIZE=16)
//  1 Reset release, id_ready=1:
//    if_pc = 0,4,8,... on consecutive cycles, if_instr = mem[pc/4], if_valid=1 from cycle 1.
//  2 id_ready=0 for 3 cycles at if_pc=8:
//    if_pc/if_instr stable at 8 and imem_adr stays 12.
//    After release, next if_pc=12 with no gap and no duplicate.
//  3 redirect=1, redirect_pc=0x20 while stalled at if_pc=8:
//    if_valid=0 next cycle, then if_pc=0x20, 0x24, ...
//  4 mem[5]=HALT_INSTR:
//    if_pc=0x14 is issued, halted=1 and no further fire.
//    Then redirect to 0x0: halted=0 and fetch restarts at 0x0.
//  5 redirect_pc=0x22 or 0x40, or sequential fetch reaching 0x3C:
//    fault=1 and sticky; if_valid drains to 0.
//    rst_n pulse clears fault and resumes fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the LEGv8 instruction-fetch stage.
// Holds the fetch FSM states, the IF/ID bundle and address checks.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] HLT_ENC = 32'hD440_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ifid_t;

  // Redirect target is unusable if misaligned or past the memory.
  function automatic logic addr_bad(
    input logic [63:0] a,
    input logic [63:0] lim
  );
    return (a[1:0] != 2'b00) || (a >= lim);
  endfunction

  // True when the word at pc is the last one in memory.
  // Widened by one bit so pc+4 can never wrap.
  function automatic logic seq_end(
    input logic [63:0] pc,
    input logic [63:0] lim
  );
    logic [64:0] nxt;
    nxt = {1'b0, pc} + 65'(INSTR_BYTES);
    return nxt >= {1'b0, lim};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with valid/ready style control.
// Ports: load/clear/hold controls, load_data bundle in, data out, valid.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  clear,
  input  logic  hold,
  input  ifid_t load_data,
  output ifid_t data,
  output logic  valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      unique case (1'b1)
        clear: begin
          valid <= 1'b0;
        end
        load: begin
          valid <= 1'b1;
          data  <= load_data;
        end
        default: begin
          // Consumed with nothing new behind it.
          if (valid && !hold) begin
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: PC, fetch FSM and the IF/ID register.
// Ports: imem_adr/imem_instr to memory, if_* to decode, redirect, halted, fault.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] IMEM_BYTES = 64'd64,
  parameter logic [31:0] HALT_INSTR = HLT_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_adr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        halted,
  output logic        fault
);

  fetch_state_t state;
  logic [63:0]  pc;

  logic  run;
  logic  fire;
  logic  flush;
  logic  halt_now;
  logic  end_now;
  ifid_t ifid_new;
  ifid_t ifid_cur;

  assign run = (state == RUN);

  assign fire = run && !redirect &&
                (!if_valid || id_ready);

  // FAULT is terminal, so redirects are dropped there.
  assign flush = redirect && (state != FAULT);

  assign halt_now = (imem_instr == HALT_INSTR);
  assign end_now  = !halt_now &&
                    seq_end(pc, IMEM_BYTES);

  assign ifid_new.pc    = pc;
  assign ifid_new.instr = imem_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (flush) begin
      pc <= redirect_pc;
      if (addr_bad(redirect_pc, IMEM_BYTES)) begin
        state <= FAULT;
      end else begin
        state <= RUN;
      end
    end else if (fire) begin
      unique case (1'b1)
        halt_now: state <= HALTED;
        end_now:  state <= FAULT;
        default:  pc <= pc + 64'(INSTR_BYTES);
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fire),
    .clear     (flush),
    .hold      (!id_ready),
    .load_data (ifid_new),
    .data      (ifid_cur),
    .valid     (if_valid)
  );

  assign imem_adr = pc;
  assign if_pc    = ifid_cur.pc;
  assign if_instr = ifid_cur.instr;
  assign halted   = (state == HALTED);
  assign fault    = (state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 16-word instruction memory.
// Table vectors plus hand sequences for fault, reset and drain cases.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_adr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halted;
  logic        fault;

  logic [31:0] mem [16];

  int n_vec;
  int n_err;

  fetch_stage #(
    .RESET_PC   (64'h0),
    .IMEM_BYTES (64'd64),
    .HALT_INSTR (32'hD440_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_adr    (imem_adr),
    .imem_instr  (imem_instr),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fault       (fault)
  );

  assign imem_instr = (imem_adr < 64'd64) ?
                      mem[imem_adr[5:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rdr;
    logic [63:0] rpc;
    logic        v;
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] adr;
    logic        h;
    logic        f;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(
    input logic rdy, input logic rdr,
    input logic [63:0] rpc, input logic v,
    input logic [63:0] pc, input logic [31:0] ins,
    input logic [63:0] adr, input logic h,
    input logic f
  );
    vec_t t;
    t.rdy = rdy; t.rdr = rdr; t.rpc = rpc;
    t.v = v; t.pc = pc; t.ins = ins;
    t.adr = adr; t.h = h; t.f = f;
    return t;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse placed between edges.
  task automatic pulse_reset;
    redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(if_valid), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    chk("rst_adr", imem_adr, 64'h0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_out(
    input string tag, input logic v,
    input logic [63:0] pc, input logic [31:0] ins,
    input logic [63:0] adr, input logic h,
    input logic f
  );
    chk({tag, "_valid"}, 64'(if_valid), 64'(v));
    if (v) begin
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_instr"}, 64'(if_instr), 64'(ins));
    end
    chk({tag, "_adr"}, imem_adr, adr);
    chk({tag, "_halted"}, 64'(halted), 64'(h));
    chk({tag, "_fault"}, 64'(fault), 64'(f));
  endtask

  localparam logic [31:0] HLT = 32'hD440_0000;
  localparam logic [31:0] I0  = 32'h9100_0000;

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = I0 | 32'(i);
    end
    mem[5] = HLT;

    rst_n       = 1'b0;
    id_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'h0;

    // 1/2: sequential fetch and a 3-cycle stall at 8
    tbl[0]  = mk(1,0,0,     1,64'h00,I0|0,64'h04,0,0);
    tbl[1]  = mk(1,0,0,     1,64'h04,I0|1,64'h08,0,0);
    tbl[2]  = mk(1,0,0,     1,64'h08,I0|2,64'h0C,0,0);
    tbl[3]  = mk(0,0,0,     1,64'h08,I0|2,64'h0C,0,0);
    tbl[4]  = mk(0,0,0,     1,64'h08,I0|2,64'h0C,0,0);
    tbl[5]  = mk(0,0,0,     1,64'h08,I0|2,64'h0C,0,0);
    tbl[6]  = mk(1,0,0,     1,64'h0C,I0|3,64'h10,0,0);
    // 3: redirect while stalled flushes
    tbl[7]  = mk(0,0,0,     1,64'h0C,I0|3,64'h10,0,0);
    tbl[8]  = mk(0,1,64'h20,0,64'h00,I0,  64'h20,0,0);
    tbl[9]  = mk(1,0,0,     1,64'h20,I0|8,64'h24,0,0);
    tbl[10] = mk(1,0,0,     1,64'h24,I0|9,64'h28,0,0);
    tbl[11] = mk(1,1,64'h0C,0,64'h00,I0,  64'h0C,0,0);
    tbl[12] = mk(1,0,0,     1,64'h0C,I0|3,64'h10,0,0);
    // 4: HLT at 0x14, then resume by redirect
    tbl[13] = mk(1,0,0,     1,64'h10,I0|4,64'h14,0,0);
    tbl[14] = mk(1,0,0,     1,64'h14,HLT, 64'h14,1,0);
    tbl[15] = mk(1,0,0,     0,64'h00,I0,  64'h14,1,0);
    tbl[16] = mk(1,0,0,     0,64'h00,I0,  64'h14,1,0);
    tbl[17] = mk(1,1,64'h00,0,64'h00,I0,  64'h00,0,0);
    tbl[18] = mk(1,0,0,     1,64'h00,I0|0,64'h04,0,0);
    // 5: misaligned redirect, then sticky fault
    tbl[19] = mk(0,1,64'h22,0,64'h00,I0,  64'h22,0,1);
    tbl[20] = mk(1,1,64'h00,0,64'h00,I0,  64'h22,0,1);
    tbl[21] = mk(1,0,0,     0,64'h00,I0,  64'h22,0,1);

    #12;
    chk("reset_valid", 64'(if_valid), 64'h0);
    chk("reset_pc", if_pc, 64'h0);
    chk("reset_instr", 64'(if_instr), 64'h0);
    chk("reset_adr", imem_adr, 64'h0);
    chk("reset_halted", 64'(halted), 64'h0);
    chk("reset_fault", 64'(fault), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      id_ready    = tbl[i].rdy;
      redirect    = tbl[i].rdr;
      redirect_pc = tbl[i].rpc;
      step();
      chk_out($sformatf("v%0d", i), tbl[i].v,
              tbl[i].pc, tbl[i].ins, tbl[i].adr,
              tbl[i].h, tbl[i].f);
    end
    redirect = 1'b0;

    // reset clears fault and resumes at RESET_PC
    pulse_reset();
    id_ready = 1'b1;
    step();
    chk_out("r1", 1, 64'h0, I0|0, 64'h4, 0, 0);

    // out-of-range redirect target
    redirect = 1'b1;
    redirect_pc = 64'h40;
    step();
    chk_out("oor", 0, 0, 0, 64'h40, 0, 1);
    redirect = 1'b0;
    step();
    chk_out("oor2", 0, 0, 0, 64'h40, 0, 1);

    // sequential fetch runs into the last word
    pulse_reset();
    redirect = 1'b1;
    redirect_pc = 64'h30;
    step();
    chk_out("s0", 0, 0, 0, 64'h30, 0, 0);
    redirect = 1'b0;
    step();
    chk_out("s1", 1, 64'h30, I0|12, 64'h34, 0, 0);
    step();
    chk_out("s2", 1, 64'h34, I0|13, 64'h38, 0, 0);
    step();
    chk_out("s3", 1, 64'h38, I0|14, 64'h3C, 0, 0);
    step();
    chk_out("s4", 1, 64'h3C, I0|15, 64'h3C, 0, 1);
    id_ready = 1'b0;
    step();
    chk_out("s5", 1, 64'h3C, I0|15, 64'h3C, 0, 1);
    id_ready = 1'b1;
    step();
    chk_out("s6", 0, 0, 0, 64'h3C, 0, 1);

    // async reset while stalled
    pulse_reset();
    step();
    chk_out("m0", 1, 64'h0, I0|0, 64'h4, 0, 0);
    id_ready = 1'b0;
    step();
    chk_out("m1", 1, 64'h0, I0|0, 64'h4, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(if_valid), 64'h0);
    chk("mid_pc", if_pc, 64'h0);
    chk("mid_adr", imem_adr, 64'h0);
    #1;
    rst_n = 1'b1;
    id_ready = 1'b1;
    step();
    chk_out("m2", 1, 64'h0, I0|0, 64'h4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
